// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, selects next fetch PC.
// Define BP_STATS_EN to build the branch / mispredict event counters (outputs read 0 otherwise).
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pcf_i,
  output logic            predtakenf_o,
  output logic [XLEN-1:0] pcnextf_o,
  input  logic            updatee_i,
  input  logic [XLEN-1:0] pce_i,
  input  logic            takene_i,
  input  logic [XLEN-1:0] targete_i,
  input  logic            predtakene_i,
  input  logic [XLEN-1:0] predtargete_i,
  output logic            mispredicte_o,
  output logic [31:0]     brcount_o,
  output logic [31:0]     mispcount_o
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TW   = XLEN - IDXW - 2;
  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [IDXW-1:0]    f_idx, e_idx;
  logic [TW-1:0]      f_tag, e_tag;
  logic               f_hit, e_hit;
  logic [1:0]         e_ctr, ctr_d;
  assign f_idx = pcf_i[IDXW+1:2];
  assign f_tag = pcf_i[XLEN-1:IDXW+2];
  assign e_idx = pce_i[IDXW+1:2];
  assign e_tag = pce_i[XLEN-1:IDXW+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_ctr = ctr_q[e_idx];
  assign ctr_d = takene_i ? ((&e_ctr) ? e_ctr : e_ctr + 2'd1)
                          : ((|e_ctr) ? e_ctr - 2'd1 : e_ctr);
  // Array reads are pre-update, so a same-cycle write never bypasses into the lookup.
  assign predtakenf_o  = reset && f_hit && ctr_q[f_idx][1];
  assign pcnextf_o     = predtakenf_o ? target_q[f_idx] : pcf_i + XLEN'(4);
  assign mispredicte_o = reset && updatee_i &&
                         ((predtakene_i != takene_i) || (takene_i && (predtargete_i != targete_i)));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (updatee_i) begin
      if (takene_i) begin
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= targete_i;
      end
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_d;
      end else if (takene_i) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= 2'b10;
      end
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] brcount_q, mispcount_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brcount_q   <= '0;
      mispcount_q <= '0;
    end else begin
      if (updatee_i) brcount_q <= brcount_q + 32'd1;
      if (mispredicte_o) mispcount_q <= mispcount_q + 32'd1;
    end
  end
  assign brcount_o   = brcount_q;
  assign mispcount_o = mispcount_q;
`else
  assign brcount_o   = '0;
  assign mispcount_o = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, reset and stats counters.
module tb_branch_predictor;
  logic        clk = 0;
  logic        reset;
  logic [31:0] pcf_i, pcnextf_o, pce_i, targete_i, predtargete_i, brcount_o, mispcount_o;
  logic        predtakenf_o, updatee_i, takene_i, predtakene_i, mispredicte_o;
  int          n_pass = 0, n_total = 0, exp_br = 0, exp_misp = 0;

  branch_predictor dut (
    .clk(clk), .reset(reset), .pcf_i(pcf_i), .predtakenf_o(predtakenf_o), .pcnextf_o(pcnextf_o),
    .updatee_i(updatee_i), .pce_i(pce_i), .takene_i(takene_i), .targete_i(targete_i),
    .predtakene_i(predtakene_i), .predtargete_i(predtargete_i), .mispredicte_o(mispredicte_o),
    .brcount_o(brcount_o), .mispcount_o(mispcount_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] nxt);
    pcf_i = pc;
    #1;
    check({tag, "_taken"}, {31'd0, predtakenf_o}, {31'd0, t});
    check({tag, "_next"}, pcnextf_o, nxt);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg, input logic exp_m);
    updatee_i = 1; pce_i = pc; takene_i = tk; targete_i = tg; predtakene_i = ptk; predtargete_i = ptg;
    #1;
    check({tag, "_misp"}, {31'd0, mispredicte_o}, {31'd0, exp_m});
    exp_br++;
    if (exp_m) exp_misp++;
    @(posedge clk); #1;
    updatee_i = 0;
  endtask

  initial begin
    reset = 0; pcf_i = 32'h100;
    updatee_i = 1; pce_i = 32'h100; takene_i = 1; targete_i = 32'h300;
    predtakene_i = 0; predtargete_i = 0;
    #1;
    check("rst_taken", {31'd0, predtakenf_o}, 32'd0);
    check("rst_next", pcnextf_o, 32'h104);
    check("rst_misp", {31'd0, mispredicte_o}, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    updatee_i = 0;
    reset = 1;
    look("post_rst", 32'h100, 0, 32'h104);
    look("wrap", 32'hFFFF_FFFC, 0, 32'h0);

    upd("alloc", 32'h40, 1, 32'h20, 0, 32'h0, 1);
    look("alloc_hit", 32'h40, 1, 32'h20);
    upd("nt1", 32'h40, 0, 32'h0, 1, 32'h20, 1);
    look("ctr01", 32'h40, 0, 32'h44);
    upd("t1", 32'h40, 1, 32'h20, 0, 32'h0, 1);
    look("ctr10", 32'h40, 1, 32'h20);
    upd("t2", 32'h40, 1, 32'h20, 1, 32'h20, 0);
    upd("t3", 32'h40, 1, 32'h20, 1, 32'h20, 0);
    upd("nt2", 32'h40, 0, 32'h0, 1, 32'h20, 1);
    look("hyst", 32'h40, 1, 32'h20);

    upd("alias", 32'h80, 1, 32'h200, 0, 32'h0, 1);
    look("evicted", 32'h40, 0, 32'h44);
    look("alias_hit", 32'h80, 1, 32'h200);
    look("other_idx", 32'h44, 0, 32'h48);

    upd("realloc", 32'h40, 1, 32'h20, 0, 32'h0, 1);
    look("realloc_hit", 32'h40, 1, 32'h20);
    pcf_i = 32'h40;
    updatee_i = 1; pce_i = 32'h40; takene_i = 1; targete_i = 32'h60; predtakene_i = 1; predtargete_i = 32'h20;
    #1;
    check("tgt_misp", {31'd0, mispredicte_o}, 32'd1);
    check("rdw_old", pcnextf_o, 32'h20);
    exp_br++; exp_misp++;
    @(posedge clk); #1;
    updatee_i = 0;
    look("rdw_new", 32'h40, 1, 32'h60);
    look("alias_gone", 32'h80, 0, 32'h84);

    takene_i = 1; predtakene_i = 0;
    #1;
    check("idle_misp", {31'd0, mispredicte_o}, 32'd0);
    upd("nt_miss", 32'hC0, 0, 32'h0, 0, 32'h0, 0);
    look("nt_noalloc", 32'hC0, 0, 32'hC4);

`ifdef BP_STATS_EN
    check("brcount", brcount_o, exp_br);
    check("mispcount", mispcount_o, exp_misp);
`else
    check("brcount", brcount_o, 32'd0);
    check("mispcount", mispcount_o, 32'd0);
`endif

    #2 reset = 0;
    look("async_rst", 32'h40, 0, 32'h44);
    check("rst_brcount", brcount_o, 32'd0);
    check("rst_mispcount", mispcount_o, 32'd0);
    @(posedge clk); #2 reset = 1;
    look("after_rst", 32'h40, 0, 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor sitting directly upstream of the IF stage of the RV32I pipelined core; it selects the next fetch PC.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Looks up the fetch PC combinationally every cycle and outputs a predicted-taken flag plus the next PC.
- Trained from the EX stage once the branch or jump outcome is resolved.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256. IDXW = log2(ENTRIES).
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pcf_i  in  XLEN  current fetch PC.
- predtakenf_o  out  1  prediction for pcf_i: taken.
- pcnextf_o  out  XLEN  predicted next PC: the BTB target if predtakenf_o=1, else pcf_i+4.
- updatee_i  in  1  EX holds a resolved branch/jump; train this cycle.
- pce_i  in  XLEN  PC of the resolved instruction.
- takene_i  in  1  actual outcome (jumps always 1).
- targete_i  in  XLEN  actual target address.
- predtakene_i  in  1  prediction that instruction carried down the pipe.
- predtargete_i  in  XLEN  predicted target carried down the pipe.
- mispredicte_o  out  1  combinational, only when updatee_i=1: (predtakene_i != takene_i) or (takene_i and predtargete_i != targete_i); 0 when updatee_i=0.

Behaviour:
- Indexing:
  - index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; bits [1:0] ignored.
- Storage per entry: valid (1), tag, target (XLEN), ctr (2 bits).
  - ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (reset=0, asynchronous):
  - all valid=0, all ctr=01; target/tag contents don't-care.
  - Outputs while in reset: predtakenf_o=0, pcnextf_o=pcf_i+4, mispredicte_o=0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx]==tag(pcf_i)).
  - predtakenf_o = hit & ctr[idx][1].
  - pcnextf_o = predtakenf_o ? target[idx] : pcf_i+4; the addition wraps mod 2^XLEN.
- Update (rising edge with updatee_i=1, indexed by pce_i):
  - Hit, taken: ctr = sat_inc(ctr) (11 stays 11); target <= targete_i.
  - Hit, not taken: ctr = sat_dec(ctr) (00 stays 00); target unchanged.
  - Miss, taken: allocate (evict any resident entry): valid=1, tag, target=targete_i, ctr=10.
  - Miss, not taken: no state change.
- updatee_i=0: no state change.
- Read-during-write: when fetch and update address the same index in one cycle, the lookup sees the pre-update contents; there is no bypass. The new value is visible from the next cycle.
- At most one update per cycle; no multi-cycle operations; no stall input. Fetch stall/flush is handled by the hazard unit by holding pcf_i.
- Reset asserted mid-operation clears all entries immediately; an update coincident with reset is dropped.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Two 32-bit registers: brcount_o (counts cycles with updatee_i=1) and mispcount_o (counts cycles with mispredicte_o=1).
  - Both reset to 0 and wrap at 2^32.
- Not defined: brcount_o and mispcount_o are tied to 0 and no counter flops are generated. The port list is identical in both builds.

Test Plan:
- Reset:
  - Stimulus: reset=0, pcf_i=0x100.
  - Required: predtakenf_o=0, pcnextf_o=0x104; after release, any PC still predicts not taken.
- Allocate and predict:
  - Stimulus: update pce_i=0x40, takene_i=1, targete_i=0x20, predtakene_i=0.
  - Required: mispredicte_o=1 during the update cycle; next cycle pcf_i=0x40 gives predtakenf_o=1, pcnextf_o=0x20.
- Counter hysteresis:
  - Stimulus: from ctr=10 at 0x40, one not-taken update.
  - Required: ctr=01, predict NT (pcnextf_o=0x44). Two taken updates then give ctr=11; a further taken update stays 11; one NT update still predicts taken.
- Alias eviction (ENTRIES=16):
  - Stimulus: entry for 0x40 resident; taken update at 0x80 (same index 0, different tag), target 0x200.
  - Required: 0x40 now misses (pcnextf_o=0x44); 0x80 predicts 0x200.
- Target mismatch and same-cycle read/write:
  - Stimulus: update 0x40 taken with targete_i=0x60, predtargete_i=0x20, predtakene_i=1, while pcf_i=0x40 in the same cycle.
  - Required: mispredicte_o=1; same-cycle pcnextf_o=0x20; next cycle pcnextf_o=0x60.
- BP_STATS_EN:
  - Stimulus: 5 updates of which 2 mispredict.
  - Required with macro defined: brcount_o=5, mispcount_o=2. Without macro: both read 0.
